// File: rtl/grid_buffer_if.sv
// Bundles the grid_buffer edit, evolution-engine, display and status signals.
// No latency of its own; wiring only.
// No backpressure: every strobe is accepted or dropped in the cycle it is seen.
//
// Ports (slave view = grid_buffer):
//   clear, edit_en/edit_pos/edit_val          in   sweep request and user cell edits
//   round_read_pos -> prev_status             in/out  engine read (1-cycle latency)
//   wden/round_write_pos/live                 in   engine write into the next plane
//   disp_pos -> disp_status                   in/out  display read (1-cycle latency)
//   busy, plane_sel, gen_done, gen_count      out  status
interface grid_buffer_if #(
    parameter int WIDTH = 12
);
    logic                 clear;
    logic                 edit_en;
    logic [2*WIDTH-1:0]   edit_pos;
    logic                 edit_val;
    logic [2*WIDTH-1:0]   round_read_pos;
    logic                 prev_status;
    logic                 wden;
    logic [2*WIDTH-1:0]   round_write_pos;
    logic                 live;
    logic [2*WIDTH-1:0]   disp_pos;
    logic                 disp_status;
    logic                 busy;
    logic                 plane_sel;
    logic                 gen_done;
    logic [15:0]          gen_count;

    modport master (
        output clear, edit_en, edit_pos, edit_val, round_read_pos,
               wden, round_write_pos, live, disp_pos,
        input  prev_status, disp_status, busy, plane_sel, gen_done, gen_count
    );

    modport slave (
        input  clear, edit_en, edit_pos, edit_val, round_read_pos,
               wden, round_write_pos, live, disp_pos,
        output prev_status, disp_status, busy, plane_sel, gen_done, gen_count
    );
endinterface

// File: rtl/grid_buffer.sv
// Double-buffered M x N cell grid: engine reads "current", writes "next", planes swap per generation.
// Reads are registered with one cycle of latency; writes take effect on the next edge.
// No backpressure: during a clear sweep (busy=1) edits and engine writes are dropped and reads return 0.
//
// Ports:
//   clk, rst   single clock, synchronous active-high reset (restarts the clear sweep)
//   gb         grid_buffer_if slave: edit port, engine read/write ports, display read port, status
module grid_buffer #(
    parameter int P_PARAM_M = 5,
    parameter int P_PARAM_N = 5,
    parameter int WIDTH     = 12
) (
    input  logic          clk,
    input  logic          rst,
    grid_buffer_if.slave  gb
);
    localparam int              CELLS = P_PARAM_M * P_PARAM_N;
    localparam int              AW    = 2 * WIDTH;
    localparam int              IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [AW-1:0]   LAST  = AW'(CELLS - 1);
    localparam logic [AW-1:0]   ONE   = AW'(1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t             state;
    logic [CELLS-1:0]   plane0;
    logic [CELLS-1:0]   plane1;
    logic [CELLS-1:0]   cur_plane;
    logic [AW-1:0]      clr_addr;
    logic [AW-1:0]      wr_count;
    logic [15:0]        gen_count;
    logic               busy;
    logic               plane_sel;
    logic               gen_done;
    logic               prev_status;
    logic               disp_status;

    // Address range checks; indices are only used when the matching check passes.
    logic               rd_ok;
    logic               disp_ok;
    logic               wr_ok;
    logic               edit_ok;
    logic [IW-1:0]      rd_idx;
    logic [IW-1:0]      disp_idx;
    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      edit_idx;
    logic [IW-1:0]      clr_idx;

    assign rd_ok    = gb.round_read_pos  <= LAST;
    assign disp_ok  = gb.disp_pos        <= LAST;
    assign wr_ok    = gb.round_write_pos <= LAST;
    assign edit_ok  = gb.edit_pos        <= LAST;
    assign rd_idx   = gb.round_read_pos[IW-1:0];
    assign disp_idx = gb.disp_pos[IW-1:0];
    assign wr_idx   = gb.round_write_pos[IW-1:0];
    assign edit_idx = gb.edit_pos[IW-1:0];
    assign clr_idx  = clr_addr[IW-1:0];

    always_comb begin
        cur_plane = plane0;
        if (plane_sel) begin
            cur_plane = plane1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CLEAR;
            clr_addr    <= '0;
            plane_sel   <= 1'b0;
            wr_count    <= '0;
            gen_count   <= '0;
            gen_done    <= 1'b0;
            prev_status <= 1'b0;
            disp_status <= 1'b0;
            busy        <= 1'b1;
        end else begin
            gen_done <= 1'b0;

            // Reads sample the plane before any write of this edge lands, so a
            // same-cycle read/write returns the old value, and a read issued with
            // the final write of a generation still sees the old current plane.
            prev_status <= (state == S_READY) && rd_ok   && cur_plane[rd_idx];
            disp_status <= (state == S_READY) && disp_ok && cur_plane[disp_idx];

            case (state)
                S_CLEAR: begin
                    plane0[clr_idx] <= 1'b0;
                    plane1[clr_idx] <= 1'b0;
                    if (clr_addr == LAST) begin
                        state <= S_READY;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + ONE;
                    end
                end

                S_READY: begin
                    if (gb.clear) begin
                        state     <= S_CLEAR;
                        clr_addr  <= '0;
                        plane_sel <= 1'b0;
                        wr_count  <= '0;
                        gen_count <= '0;
                        busy      <= 1'b1;
                    end else begin
                        // User edits only land between generations, into the
                        // current plane; the engine always writes the other plane,
                        // so both can happen in the same cycle.
                        if (gb.edit_en && edit_ok && (wr_count == '0)) begin
                            if (plane_sel) begin
                                plane1[edit_idx] <= gb.edit_val;
                            end else begin
                                plane0[edit_idx] <= gb.edit_val;
                            end
                        end

                        if (gb.wden && wr_ok) begin
                            if (plane_sel) begin
                                plane0[wr_idx] <= gb.live;
                            end else begin
                                plane1[wr_idx] <= gb.live;
                            end

                            if (wr_count == LAST) begin
                                wr_count  <= '0;
                                plane_sel <= ~plane_sel;
                                gen_count <= gen_count + 16'd1;
                                gen_done  <= 1'b1;
                            end else begin
                                wr_count <= wr_count + ONE;
                            end
                        end
                    end
                end

                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    assign gb.prev_status = prev_status;
    assign gb.disp_status = disp_status;
    assign gb.busy        = busy;
    assign gb.plane_sel   = plane_sel;
    assign gb.gen_done    = gen_done;
    assign gb.gen_count   = gen_count;
endmodule

// File: tb/tb_grid_buffer.sv
// Self-checking bench for grid_buffer (M=N=5, WIDTH=12).
// Reads push their expected value to a scoreboard when issued; it is drained after the next edge.
// Status outputs are compared against a behavioural model every cycle.
module tb_grid_buffer;
    localparam int M     = 5;
    localparam int N     = 5;
    localparam int W     = 12;
    localparam int CELLS = M * N;
    localparam int AW    = 2 * W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    grid_buffer_if #(.WIDTH(W)) gb ();

    grid_buffer #(
        .P_PARAM_M (M),
        .P_PARAM_N (N),
        .WIDTH     (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .gb  (gb)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic port;   // 0: disp_status, 1: prev_status
        logic exp;
    } sb_t;

    sb_t sb[$];

    // Behavioural model of the grid state.
    bit          m_pl [2][CELLS];
    bit          m_ready = 1'b0;
    int          m_clr   = 0;
    int          m_wr    = 0;
    bit          m_sel   = 1'b0;
    bit          m_done  = 1'b0;
    logic [15:0] m_gen   = '0;

    int pulses;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic mread(input int a);
        if (!m_ready || a < 0 || a >= CELLS) begin
            return 1'b0;
        end
        return m_pl[m_sel][a];
    endfunction

    task automatic model_step();
        int ep;
        int wp;
        ep     = int'(gb.edit_pos);
        wp     = int'(gb.round_write_pos);
        m_done = 1'b0;
        if (rst) begin
            m_ready = 1'b0; m_clr = 0; m_sel = 1'b0; m_wr = 0; m_gen = '0;
        end else if (!m_ready) begin
            m_pl[0][m_clr] = 1'b0;
            m_pl[1][m_clr] = 1'b0;
            if (m_clr == CELLS - 1) m_ready = 1'b1;
            else m_clr++;
        end else if (gb.clear) begin
            m_ready = 1'b0; m_clr = 0; m_sel = 1'b0; m_wr = 0; m_gen = '0;
        end else begin
            if (gb.edit_en && m_wr == 0 && ep < CELLS) m_pl[m_sel][ep] = gb.edit_val;
            if (gb.wden && wp < CELLS) begin
                m_pl[!m_sel][wp] = gb.live;
                if (m_wr == CELLS - 1) begin
                    m_wr = 0; m_sel = !m_sel; m_gen = m_gen + 16'd1; m_done = 1'b1;
                end else begin
                    m_wr++;
                end
            end
        end
    endtask

    // One clock: queue expected read results, advance the model, then compare after the edge.
    task automatic tick();
        sb_t e;
        e.port = 1'b0; e.exp = mread(int'(gb.disp_pos));       sb.push_back(e);
        e.port = 1'b1; e.exp = mread(int'(gb.round_read_pos)); sb.push_back(e);
        model_step();
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port) check_eq("prev_status", 32'(gb.prev_status), 32'(e.exp));
            else        check_eq("disp_status", 32'(gb.disp_status), 32'(e.exp));
        end
        check_eq("busy",      32'(gb.busy),      32'(!m_ready));
        check_eq("plane_sel", 32'(gb.plane_sel), 32'(m_sel));
        check_eq("gen_count", 32'(gb.gen_count), 32'(m_gen));
        check_eq("gen_done",  32'(gb.gen_done),  32'(m_done));
    endtask

    task automatic idle();
        gb.clear   = 1'b0;
        gb.edit_en = 1'b0;
        gb.wden    = 1'b0;
    endtask

    task automatic rd(input int d, input int r);
        gb.disp_pos       = AW'(d);
        gb.round_read_pos = AW'(r);
    endtask

    // Called right after the edge that started a sweep; counts cycles with busy high.
    task automatic count_busy(input string tag, input int want);
        int n;
        n = 0;
        for (int i = 0; i < 100 && gb.busy; i++) begin
            rd(int'($urandom_range(0, CELLS + 5)), int'($urandom_range(0, CELLS - 1)));
            n++;
            tick();
        end
        check_eq(tag, 32'(n), 32'(want));
    endtask

    task automatic read_all();
        idle();
        for (int i = 0; i < CELLS; i++) begin
            rd(i, CELLS - 1 - i);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rd(0, 0);
        gb.edit_pos        = '0;
        gb.edit_val        = 1'b0;
        gb.round_write_pos = '0;
        gb.live            = 1'b0;

        // Reset overrides a simultaneous engine write and edit.
        rst         = 1'b1;
        gb.wden     = 1'b1;
        gb.live     = 1'b1;
        gb.edit_en  = 1'b1;
        gb.edit_val = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check_eq("rst_busy",      32'(gb.busy),      32'd1);
        check_eq("rst_plane_sel", 32'(gb.plane_sel), 32'd0);
        count_busy("reset_sweep_len", 25);
        check_eq("ready_gen_count", 32'(gb.gen_count), 32'd0);
        read_all();

        // Edit cell 7; a read in the same cycle sees the old value.
        gb.edit_en = 1'b1; gb.edit_pos = AW'(7); gb.edit_val = 1'b1;
        rd(7, 7);
        tick();
        idle();
        rd(7, 7);
        tick();
        check_eq("edit_disp_7", 32'(gb.disp_status), 32'd1);
        check_eq("edit_prev_7", 32'(gb.prev_status), 32'd1);

        // Out-of-range reads return 0.
        rd(CELLS, 'hFFFFFF);
        tick();

        // Generation 1: all-live writes, with an edit alongside the first write,
        // and an out-of-range write plus a late edit when wr_count is 3.
        pulses = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (i == 3) begin
                idle();
                gb.wden = 1'b1; gb.round_write_pos = AW'(30); gb.live = 1'b1;
                gb.edit_en = 1'b1; gb.edit_pos = AW'(0); gb.edit_val = 1'b1;
                rd(0, 3);
                tick();
                if (gb.gen_done) pulses++;
                idle();
                rd(0, 0);
                tick();
                check_eq("late_edit_dropped", 32'(gb.disp_status), 32'd0);
            end
            idle();
            gb.wden = 1'b1; gb.round_write_pos = AW'(i); gb.live = 1'b1;
            if (i == 0) begin
                gb.edit_en = 1'b1; gb.edit_pos = AW'(3); gb.edit_val = 1'b1;
            end
            rd(i, i);
            tick();
            if (gb.gen_done) pulses++;
        end
        idle();
        rd(3, 24);
        tick();
        if (gb.gen_done) pulses++;
        check_eq("gen1_done_pulses", 32'(pulses), 32'd1);
        check_eq("gen1_plane_sel",   32'(gb.plane_sel), 32'd1);
        check_eq("gen1_gen_count",   32'(gb.gen_count), 32'd1);
        check_eq("gen1_read_3",      32'(gb.disp_status), 32'd1);
        read_all();

        // Generation 2: random values, occasional idle cycles.
        for (int i = 0; i < CELLS; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                rd(int'($urandom_range(0, CELLS - 1)), i);
                tick();
            end
            idle();
            gb.wden = 1'b1; gb.round_write_pos = AW'(i); gb.live = 1'($urandom_range(0, 1));
            rd(i, int'($urandom_range(0, CELLS - 1)));
            tick();
        end
        idle();
        check_eq("gen2_plane_sel", 32'(gb.plane_sel), 32'd0);
        check_eq("gen2_gen_count", 32'(gb.gen_count), 32'd2);
        read_all();

        // Clear after two generations.
        gb.clear = 1'b1;
        tick();
        idle();
        count_busy("clear_sweep_len", 25);
        check_eq("clear_plane_sel", 32'(gb.plane_sel), 32'd0);
        check_eq("clear_gen_count", 32'(gb.gen_count), 32'd0);
        read_all();

        // Reset in the middle of a generation restarts the sweep.
        for (int i = 0; i < 5; i++) begin
            idle();
            gb.wden = 1'b1; gb.round_write_pos = AW'(i); gb.live = 1'b1;
            rd(i, i);
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy("rst_midgen_sweep_len", 25);

        // Reset at sweep cycle 10 restarts a full 25-cycle sweep.
        gb.clear = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 9; i++) begin
            rd(i, i);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy("rst_midsweep_len", 25);
        check_eq("final_plane_sel", 32'(gb.plane_sel), 32'd0);
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/grid_buffer.md
GRID_BUFFER -- requirements
Module: grid_buffer

Interface
REQ-001 Parameter P_PARAM_M, default 5, grid rows.
REQ-002 Parameter P_PARAM_N, default 5, grid columns.
REQ-003 Parameter WIDTH, default 12, coordinate width; linear addresses are 2*WIDTH bits, addr = row*P_PARAM_N + col.
REQ-004 clk  in  1  single global clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 clear  in  1  level; request to zero both planes.
REQ-007 edit_en  in  1  user cell write strobe.
REQ-008 edit_pos  in  2*WIDTH  user write address.
REQ-009 edit_val  in  1  user write value.
REQ-010 round_read_pos  in  2*WIDTH  evolution-engine read address.
REQ-011 prev_status  out  1  registered cell value at round_read_pos of previous cycle.
REQ-012 wden  in  1  evolution-engine write strobe.
REQ-013 round_write_pos  in  2*WIDTH  evolution-engine write address.
REQ-014 live  in  1  evolution-engine write value.
REQ-015 disp_pos  in  2*WIDTH  display read address.
REQ-016 disp_status  out  1  registered cell value at disp_pos of previous cycle.
REQ-017 busy  out  1  high while clear sweep runs.
REQ-018 plane_sel  out  1  index of current (readable) plane.
REQ-019 gen_done  out  1  one-cycle pulse after a generation completes.
REQ-020 gen_count  out  16  completed-generation counter.

Function
REQ-021 Storage SHALL be two bit planes of P_PARAM_M*P_PARAM_N cells; "current" = plane_sel, "next" = !plane_sel.
REQ-022 States SHALL be S_CLEAR and S_READY only.
REQ-023 S_CLEAR: clr_addr from 0 to M*N-1, one address per cycle, writes 0 to that address in both planes; busy=1; at clr_addr==M*N-1 -> S_READY next cycle, busy=0 in S_READY.
REQ-024 S_CLEAR: edit and wden writes ignored; prev_status and disp_status SHALL read 0.
REQ-025 S_READY: clear=1 -> S_CLEAR next cycle, clr_addr=0, plane_sel=0, wr_count=0, gen_count=0.
REQ-026 Reads: prev_status = current[round_read_pos], disp_status = current[disp_pos], one-cycle latency, registered; address >= M*N returns 0.
REQ-027 Read and write same address same cycle SHALL return the pre-write value.
REQ-028 wden=1 in S_READY with round_write_pos < M*N: next[round_write_pos] <= live, wr_count increments.
REQ-029 wden with address >= M*N SHALL be ignored and SHALL NOT count.
REQ-030 Counted write with wr_count == M*N-1: plane_sel toggles, wr_count=0, gen_count+1 (wraps 0xFFFF->0), gen_done=1 next cycle only.
REQ-031 A read issued in the cycle of the final write SHALL still address the old current plane.
REQ-032 edit_en in S_READY with wr_count==0 and edit_pos < M*N: current[edit_pos] <= edit_val; otherwise edit dropped.
REQ-033 edit and wden same cycle with wr_count==0: both SHALL take effect (different planes).
REQ-034 wr_count SHALL be 2*WIDTH bits; arithmetic unsigned, no overflow beyond M*N.

Reset
REQ-035 rst=1 SHALL force S_CLEAR, clr_addr=0, plane_sel=0, wr_count=0, gen_count=0, gen_done=0, prev_status=0, disp_status=0, busy=1 on the next edge, overriding clear, edit and wden.
REQ-036 rst asserted mid-sweep or mid-generation SHALL restart the full sweep from address 0.

Verification
REQ-037 Reset, M=N=5: busy high exactly 25 cycles, then busy=0, plane_sel=0, gen_count=0, all disp_status reads 0.
REQ-038 Edit pos 7 val 1, then disp_pos=7 -> disp_status=1 one cycle later; round_read_pos=7 -> prev_status=1 one cycle later.
REQ-039 25 wden writes live=1 pos 0..24 -> plane_sel 0->1 after 25th, gen_done pulses once, gen_count=1, all reads return 1.
REQ-040 wden pos 30 -> ignored, wr_count unchanged; edit_en while wr_count=3 -> current plane unchanged.
REQ-041 clear after gen_count=2 -> 25-cycle sweep, plane_sel=0, gen_count=0, all cells 0; rst at sweep cycle 10 -> sweep restarts, busy lasts 25 more cycles.
